mbist_controller: RTL and testbench
===================================

// Module: mbist_controller
// PURPOSE
//  March-style MBIST sequencer for one SRAM. It drives the 3-bit pattern select q into the pattern decoder and receives
//  the 8-bit background data_t back. For each pattern it writes data_t to every address, then reads every address back.
//  It compares each read against data_t and logs failures. It sits between the test-access start/status interface and the
//  memory under test.
// PARAMETERS
//  ADDR_WIDTH   6  memory address width; pass length = 2**ADDR_WIDTH
//  DATA_WIDTH   8  memory word width; must equal decoder output width
//  NUM_PATTERNS 6  patterns run, q = 0..NUM_PATTERNS-1 (codes 0-5 defined)
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  start      in   1           one-cycle request to begin a run
//  q          out  3           pattern select to decoder
//  data_t     in   DATA_WIDTH  pattern from decoder (combinational from q)
//  addr       out  ADDR_WIDTH  memory address
//  mem_we     out  1           memory write enable; write data = data_t
//  mem_re     out  1           memory read enable
//  mem_rdata  in   DATA_WIDTH  read data, valid 1 cycle after mem_re
//  busy       out  1           run in progress
//  done       out  1           run complete; held until next start or rst
//  fail       out  1           sticky: at least one miscompare this run
//  fail_addr  out  ADDR_WIDTH  address of first miscompare
//  fail_q     out  3           pattern of first miscompare
//  fail_data  out  DATA_WIDTH  mem_rdata captured at first miscompare
//  err_count  out  8           miscompare count, saturates at 8'hFF
// BEHAVIOUR
//  - Reset: every output 0, state IDLE. Applies immediately, at any point including mid-pass; no memory cleanup.
//  - FSM: IDLE -> WRITE -> READ -> DRAIN -> (WRITE with q+1 | DONE).
//    All outputs are registered. start is sampled in IDLE or DONE only.
//  - start in IDLE/DONE: the next cycle enters WRITE with q=0 and addr=0, busy=1 and done=0.
//    The same edge clears fail, fail_* and err_count. start while busy is ignored.
//  - WRITE: mem_we=1 for 2**AW cycles, addr 0..max ascending. After the last address, go to READ with addr=0.
//  - READ: mem_re=1 for 2**AW cycles, addr 0..max.
//    A one-stage compare pipeline holds the valid flag, addr and q of each read.
//  - DRAIN: mem_we=mem_re=0 for 1 cycle so the final read is compared.
//    Then: if q==NUM_PATTERNS-1, go to DONE (busy=0, done=1); else q+=1, addr=0, go to WRITE.
//  - q and data_t are constant during a pattern's WRITE and READ passes.
//  - Compare: one cycle after each read, the pipeline compares mem_rdata with data_t. Any mismatch (!==, so X/Z counts
//    as fail) increments err_count, saturating. The first mismatch sets fail and latches fail_addr, fail_q and fail_data.
//    Later mismatches do not overwrite them.
//  - mem_we and mem_re are never both 1. addr wraps to 0 at each pass boundary.
//  - Run length: NUM_PATTERNS*(2*2**AW+1) cycles from the first WRITE cycle to the first DONE cycle.
// STRUCTURE
//  - mbist_pkg: state_t enum {IDLE,WRITE,READ,DRAIN,DONE}; NUM_PATTERNS_MAX=6;
//    pattern codes Q_CHECK=0, Q_ICHECK=1, Q_HIHALF=2, Q_LOHALF=3, Q_ZEROS=4, Q_ONES=5.
//  - Sub-module mbist_comparator: the compare pipeline stage with first-fail capture and the saturating err_count.
//  - The FSM and address/pattern counters stay in mbist_controller.
// TESTING (ADDR_WIDTH=2, real decoder, behavioural 1-cycle SRAM)
//  - Fault-free: pulse start -> busy=1 next cycle. done=1 after 54 cycles; fail=0, err_count=0.
//  - Sequencing: q goes 0,1,2,3,4,5. Each pattern gives 4 mem_we cycles then 4 mem_re cycles, addr 0..3; never we&re.
//  - Bit 0 stuck-at-0 at addr 2: fail=1, fail_addr=2, fail_q=1, fail_data=8'b01010100, err_count=3.
//  - Pulse start in the middle of a READ pass: the run is unaffected and done still arrives at cycle 54.
//  - Assert rst during q=3 READ: outputs are 0 at once and the FSM is in IDLE. A new start gives a full clean run.
//  - Rerun from DONE after a faulty run with the fault removed: fail, fail_* and err_count clear on start; end with fail=0.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types and constants for the March-style MBIST sequencer.
// Contents: FSM state encoding, pattern-select codes, pattern-select width,
//           and a reference pattern decoder function.
package mbist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam int NUM_PATTERNS_MAX = 6;
  localparam int Q_WIDTH          = 3;

  // Pattern-select codes understood by the background decoder.
  localparam logic [Q_WIDTH-1:0] Q_CHECK  = 3'd0;
  localparam logic [Q_WIDTH-1:0] Q_ICHECK = 3'd1;
  localparam logic [Q_WIDTH-1:0] Q_HIHALF = 3'd2;
  localparam logic [Q_WIDTH-1:0] Q_LOHALF = 3'd3;
  localparam logic [Q_WIDTH-1:0] Q_ZEROS  = 3'd4;
  localparam logic [Q_WIDTH-1:0] Q_ONES   = 3'd5;

  // Reference 8-bit decoder: the background word driven for each code.
  function automatic logic [7:0] pattern_data(input logic [Q_WIDTH-1:0] sel);
    logic [7:0] d;
    case (sel)
      Q_CHECK:  d = 8'hAA;
      Q_ICHECK: d = 8'h55;
      Q_HIHALF: d = 8'hF0;
      Q_LOHALF: d = 8'h0F;
      Q_ZEROS:  d = 8'h00;
      Q_ONES:   d = 8'hFF;
      default:  d = 8'h00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mbist_comparator.sv
// Read-compare stage: holds one read in flight, compares it with the background
// one cycle later, counts miscompares (saturating) and captures the first one.
// Ports: clk/rst; clear_i (start of run); rd_vld_i/rd_addr_i/rd_q_i (read issued
//        this cycle); data_t_i (expected word); rdata_i (memory data, 1 cycle
//        after the read); fail_o, fail_addr_o, fail_q_o, fail_data_o, err_count_o.
module mbist_comparator
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  rd_vld_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [Q_WIDTH-1:0]    rd_q_i,
  input  logic [DATA_WIDTH-1:0] data_t_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [Q_WIDTH-1:0]    fail_q_o,
  output logic [DATA_WIDTH-1:0] fail_data_o,
  output logic [7:0]            err_count_o
);

  logic                  pipe_vld_q,  pipe_vld_d;
  logic [ADDR_WIDTH-1:0] pipe_addr_q, pipe_addr_d;
  logic [Q_WIDTH-1:0]    pipe_pat_q,  pipe_pat_d;
  logic                  fail_flag_q, fail_flag_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [Q_WIDTH-1:0]    fail_pat_q,  fail_pat_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
  logic [7:0]            err_q,       err_d;
  logic                  mismatch;

  always_comb begin
    pipe_vld_d  = rd_vld_i;
    pipe_addr_d = rd_addr_i;
    pipe_pat_d  = rd_q_i;
    fail_flag_d = fail_flag_q;
    fail_addr_d = fail_addr_q;
    fail_pat_d  = fail_pat_q;
    fail_data_d = fail_data_q;
    err_d       = err_q;
    // Case inequality so that an X/Z read word is treated as a miscompare.
    mismatch    = pipe_vld_q && (rdata_i !== data_t_i);

    if (clear_i) begin
      pipe_vld_d  = 1'b0;
      fail_flag_d = 1'b0;
      fail_addr_d = '0;
      fail_pat_d  = '0;
      fail_data_d = '0;
      err_d       = '0;
    end else if (mismatch) begin
      if (err_q != 8'hFF) begin
        err_d = err_q + 8'd1;
      end
      // Only the first miscompare of a run is recorded.
      if (!fail_flag_q) begin
        fail_flag_d = 1'b1;
        fail_addr_d = pipe_addr_q;
        fail_pat_d  = pipe_pat_q;
        fail_data_d = rdata_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q  <= 1'b0;
      pipe_addr_q <= '0;
      pipe_pat_q  <= '0;
      fail_flag_q <= 1'b0;
      fail_addr_q <= '0;
      fail_pat_q  <= '0;
      fail_data_q <= '0;
      err_q       <= '0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
      pipe_pat_q  <= pipe_pat_d;
      fail_flag_q <= fail_flag_d;
      fail_addr_q <= fail_addr_d;
      fail_pat_q  <= fail_pat_d;
      fail_data_q <= fail_data_d;
      err_q       <= err_d;
    end
  end

  assign fail_o      = fail_flag_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_q_o    = fail_pat_q;
  assign fail_data_o = fail_data_q;
  assign err_count_o = err_q;

endmodule

// File: rtl/mbist_controller.sv
// March-style MBIST sequencer: for each pattern, write the background to every
// address, read every address back, and log miscompares via mbist_comparator.
// Ports: clk/rst; start; q (pattern select) / data_t (decoded background);
//        addr, mem_we, mem_re, mem_rdata (memory side); busy, done (status);
//        fail, fail_addr, fail_q, fail_data, err_count (result log).
module mbist_controller
  import mbist_pkg::*;
#(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_PATTERNS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [Q_WIDTH-1:0]    q,
  input  logic [DATA_WIDTH-1:0] data_t,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [Q_WIDTH-1:0]    fail_q,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [7:0]            err_count
);

  // Only codes 0..NUM_PATTERNS_MAX-1 are defined by the decoder.
  localparam int NP = (NUM_PATTERNS > NUM_PATTERNS_MAX) ? NUM_PATTERNS_MAX :
                      (NUM_PATTERNS < 1) ? 1 : NUM_PATTERNS;
  localparam logic [Q_WIDTH-1:0]    LAST_Q   = Q_WIDTH'(NP - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic [Q_WIDTH-1:0]    pat_q,   pat_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic                  we_q,    we_d;
  logic                  re_q,    re_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;
  logic                  start_ok;

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    start_ok = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = WRITE;
          pat_d    = Q_CHECK;
          addr_d   = '0;
          we_d     = 1'b1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      WRITE: begin
        if (addr_q == ADDR_MAX) begin
          state_d = READ;
          addr_d  = '0;
          re_d    = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          we_d    = 1'b1;
        end
      end
      READ: begin
        if (addr_q == ADDR_MAX) begin
          state_d = DRAIN;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + 1'b1;
          re_d    = 1'b1;
        end
      end
      DRAIN: begin
        // The last read of the pass is compared during this idle cycle,
        // so q must not advance until it is over.
        if (pat_q == LAST_Q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = WRITE;
          pat_d   = pat_q + 1'b1;
          addr_d  = '0;
          we_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  mbist_comparator #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (start_ok),
    .rd_vld_i    (re_q),
    .rd_addr_i   (addr_q),
    .rd_q_i      (pat_q),
    .data_t_i    (data_t),
    .rdata_i     (mem_rdata),
    .fail_o      (fail),
    .fail_addr_o (fail_addr),
    .fail_q_o    (fail_q),
    .fail_data_o (fail_data),
    .err_count_o (err_count)
  );

  assign q      = pat_q;
  assign addr   = addr_q;
  assign mem_we = we_q;
  assign mem_re = re_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mbist_controller.sv
// Bench for mbist_controller with a 4-word memory, a pattern decoder and an
// optional bit-0 stuck-at-0 fault at address 2.
module tb_mbist_controller;

  localparam int AW      = 2;
  localparam int DW      = 8;
  localparam int NP      = 6;
  localparam int DEPTH   = 1 << AW;
  localparam int PASS    = 2 * DEPTH + 1;
  localparam int RUN_LEN = NP * PASS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    q;
  logic [DW-1:0] data_t;
  logic [AW-1:0] addr;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_q;
  logic [DW-1:0] fail_data;
  logic [7:0]    err_count;

  mbist_controller #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .NUM_PATTERNS (NP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .q         (q),
    .data_t    (data_t),
    .addr      (addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_q    (fail_q),
    .fail_data (fail_data),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Background word for each pattern code.
  function automatic logic [DW-1:0] bg(input int p);
    logic [DW-1:0] t [NP];
    t[0] = 8'hAA; t[1] = 8'h55; t[2] = 8'hF0;
    t[3] = 8'h0F; t[4] = 8'h00; t[5] = 8'hFF;
    return (p >= 0 && p < NP) ? t[p] : 8'h00;
  endfunction

  always_comb data_t = bg(int'(q));

  // Memory with optional stuck-at-0 on bit 0 of word 2.
  logic [DW-1:0] mem [DEPTH];
  bit            fault_en = 1'b0;
  always @(posedge clk) begin
    if (mem_we) mem[addr] <= (fault_en && addr == 2) ? (data_t & 8'hFE) : data_t;
    if (mem_re) mem_rdata <= mem[addr];
  end

  int   checks = 0;
  int   errors = 0;
  bit   track  = 1'b0;
  int   cnt    = 0;
  int   busy_cycles = 0;

  logic          exp_fail;
  logic [AW-1:0] exp_faddr;
  logic [2:0]    exp_fq;
  logic [DW-1:0] exp_fdata;
  int            exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result log: every word holds the background except where the
  // fault corrupts it; any word that reads back different is a miscompare.
  task automatic compute_expect(input bit flt);
    logic [DW-1:0] stored;
    int n;
    n = 0;
    exp_fail = 1'b0; exp_faddr = '0; exp_fq = '0; exp_fdata = '0;
    for (int p = 0; p < NP; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        stored = bg(p);
        if (flt && a == 2) stored[0] = 1'b0;
        if (stored !== bg(p)) begin
          n++;
          if (!exp_fail) begin
            exp_fail  = 1'b1;
            exp_faddr = AW'(a);
            exp_fq    = 3'(p);
            exp_fdata = stored;
          end
        end
      end
    end
    exp_err = (n > 255) ? 255 : n;
  endtask

  // Advance to the next negedge and check the run against the schedule:
  // cycle k of a run is pattern k/PASS; within it, DEPTH writes, DEPTH reads,
  // one idle cycle; after RUN_LEN cycles the run reports done.
  task automatic tick();
    int  p;
    int  r;
    bit  ew;
    bit  er;
    int  ea;
    @(negedge clk);
    if (track) begin
      if (busy) busy_cycles++;
      if (cnt < RUN_LEN) begin
        p  = cnt / PASS;
        r  = cnt % PASS;
        ew = (r < DEPTH);
        er = (r >= DEPTH) && (r < 2 * DEPTH);
        ea = ew ? r : r - DEPTH;
        chk("busy_run", 32'(busy), 32'd1);
        chk("done_run", 32'(done), 32'd0);
        chk("mem_we", 32'(mem_we), 32'(ew));
        chk("mem_re", 32'(mem_re), 32'(er));
        chk("q", 32'(q), 32'(p));
        if (ew || er) chk("addr", 32'(addr), 32'(ea));
        if (cnt == 0) begin
          chk("clr_fail", 32'(fail), 32'd0);
          chk("clr_err", 32'(err_count), 32'd0);
          chk("clr_faddr", 32'(fail_addr), 32'd0);
          chk("clr_fq", 32'(fail_q), 32'd0);
          chk("clr_fdata", 32'(fail_data), 32'd0);
        end
      end else begin
        chk("busy_end", 32'(busy), 32'd0);
        chk("done_end", 32'(done), 32'd1);
        chk("we_end", 32'(mem_we), 32'd0);
        chk("re_end", 32'(mem_re), 32'd0);
        chk("fail", 32'(fail), 32'(exp_fail));
        chk("err_count", 32'(err_count), 32'(exp_err));
        chk("fail_addr", 32'(fail_addr), 32'(exp_faddr));
        chk("fail_q", 32'(fail_q), 32'(exp_fq));
        chk("fail_data", 32'(fail_data), 32'(exp_fdata));
      end
      cnt++;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_re"}, 32'(mem_re), 32'd0);
    chk({tag, "_q"}, 32'(q), 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_faddr"}, 32'(fail_addr), 32'd0);
    chk({tag, "_fq"}, 32'(fail_q), 32'd0);
    chk({tag, "_fdata"}, 32'(fail_data), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
  endtask

  // mode 0: plain run; 1: extra start pulse during a READ pass;
  // 2: reset asserted during pattern 3 READ pass.
  task automatic run(input bit flt, input int mode);
    fault_en = flt;
    compute_expect(flt);
    busy_cycles = 0;
    start = 1'b1;
    track = 1'b1;
    cnt   = 0;
    tick();
    start = 1'b0;
    for (int k = 1; k < RUN_LEN + 4; k++) begin
      start = (mode == 1 && cnt == 2 * PASS + DEPTH + 1);
      if (mode == 2 && cnt == 3 * PASS + DEPTH + 1) begin
        chk("pre_rst_q", 32'(q), 32'd3);
        chk("pre_rst_re", 32'(mem_re), 32'd1);
        track = 1'b0;
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        break;
      end
      tick();
    end
    start = 1'b0;
    track = 1'b0;
    if (mode != 2) chk("busy_cycles", 32'(busy_cycles), 32'(RUN_LEN));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    #1 chk_zero("reset");
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    chk_zero("idle");

    // Fault-free run.
    run(1'b0, 0);
    chk("ff_len", 32'(busy_cycles), 32'd54);
    chk("ff_fail", 32'(fail), 32'd0);
    chk("ff_err", 32'(err_count), 32'd0);

    // Stuck-at-0 on bit 0 of word 2: seen by patterns 1, 3 and 5.
    run(1'b1, 0);
    chk("flt_fail", 32'(fail), 32'd1);
    chk("flt_faddr", 32'(fail_addr), 32'd2);
    chk("flt_fq", 32'(fail_q), 32'd1);
    chk("flt_fdata", 32'(fail_data), 32'b01010100);
    chk("flt_err", 32'(err_count), 32'd3);

    // Rerun from DONE with the fault removed.
    run(1'b0, 0);
    chk("rerun_fail", 32'(fail), 32'd0);
    chk("rerun_err", 32'(err_count), 32'd0);

    // Start pulse while busy must be ignored.
    run(1'b0, 1);
    chk("mid_len", 32'(busy_cycles), 32'd54);

    // Reset during pattern 3 READ, then a clean run.
    run(1'b0, 2);
    repeat (2) tick();
    chk_zero("in_rst");
    rst = 1'b0;
    repeat (3) tick();
    chk_zero("post_rst");
    run(1'b0, 0);
    chk("post_rst_fail", 32'(fail), 32'd0);
    chk("post_rst_done", 32'(done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
